// File: rtl/seq_pkg.sv
// Shared definitions for the sync-pattern link: frame states, the default
// sync word and a small sizing helper used by the transmitter.
package seq_pkg;

    // Frame phases of the transmitter (the detector uses the same names).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } seq_state_e;

    // Single definition of the sync word shared by both ends of the link.
    localparam int         SYNC_DEFAULT_LEN = 4;
    localparam logic [3:0] SYNC_DEFAULT     = 4'b1001;

    // Largest of three sizes, used to dimension the shared bit counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_pattern_tx_piso_shift.sv
// Parallel-load, MSB-first shift register holding the frame payload.
module piso_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] d,
    output logic              q_msb
);

    logic [DATA_W-1:0] sreg;

    // Load the payload on an accepted start, otherwise move it up one bit.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= d;
        end else if (shift_en) begin
            sreg <= sreg << 1;
        end
    end

    assign q_msb = sreg[DATA_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: sync word, MSB-first payload, then a low guard
// gap. Drives the single-bit line watched by the sync-pattern detector.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int                  SYNC_LEN     = SYNC_DEFAULT_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = SYNC_DEFAULT,
    parameter int                  DATA_W       = 8,
    parameter int                  GAP_LEN      = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    input  logic              abort,
    output logic              ready,
    output logic              busy,
    output logic              out,
    output logic              done
);

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] SYNC = 2'(ST_SYNC);
    localparam logic [1:0] DATA = 2'(ST_DATA);
    localparam logic [1:0] GAP  = 2'(ST_GAP);

    localparam int CNT_W = $clog2(max3(SYNC_LEN, DATA_W, GAP_LEN) + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    // The final low cycle of the guard gap is spent back in IDLE so that the
    // next start is accepted exactly GAP_LEN cycles after the last payload
    // bit; the GAP state therefore covers only the first GAP_LEN-1 cycles.
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_LEN > 1) ? GAP_LEN - 2 : 0);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             kill;
    logic             load;
    logic             shift_en;
    logic             payload_bit;
    logic             sync_next;

    assign accept = (state == IDLE) && start && !abort;
    assign kill   = (state != IDLE) && abort;
    assign load   = accept;

    // Select the next sync bit and decide when the payload register advances.
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves a value unassigned and infers a latch.
    always_comb begin
        sync_next = 1'b0;
        shift_en  = 1'b0;
        for (int i = 0; i < SYNC_LEN - 1; i++) begin
            if (cnt == CNT_W'(i)) begin
                sync_next = SYNC_PATTERN[SYNC_LEN-2-i];
            end
        end
        if (!kill) begin
            if (state == SYNC && cnt == SYNC_LAST) begin
                shift_en = 1'b1;
            end else if (state == DATA && cnt != DATA_LAST) begin
                shift_en = 1'b1;
            end
        end
    end

    piso_shift #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .shift_en (shift_en),
        .d        (data),
        .q_msb    (payload_bit)
    );

    // Frame sequencer; all line and handshake outputs are registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            out   <= 1'b0;
            busy  <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b0;
        end else if (kill) begin
            state <= IDLE;
            cnt   <= '0;
            out   <= 1'b0;
            busy  <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    out  <= 1'b0;
                    if (accept) begin
                        state <= SYNC;
                        cnt   <= '0;
                        out   <= SYNC_PATTERN[SYNC_LEN-1];
                        busy  <= 1'b1;
                        ready <= 1'b0;
                    end
                end
                SYNC: begin
                    if (cnt == SYNC_LAST) begin
                        state <= DATA;
                        cnt   <= '0;
                        out   <= payload_bit;
                    end else begin
                        cnt <= cnt + 1'b1;
                        out <= sync_next;
                    end
                end
                DATA: begin
                    if (cnt == DATA_LAST) begin
                        cnt  <= '0;
                        out  <= 1'b0;
                        done <= 1'b1;
                        if (GAP_LEN > 1) begin
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        out <= payload_bit;
                    end
                end
                default: begin
                    done <= 1'b0;
                    out  <= 1'b0;
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: the driver queues the expected
// line/handshake state for each edge, a monitor compares on the falling edge.
module tb_seq_pattern_tx;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] data;
    logic       abort;
    logic       ready;
    logic       busy;
    logic       out;
    logic       done;

    typedef struct {
        logic  out;
        logic  ready;
        logic  busy;
        logic  done;
        string tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    seq_pattern_tx dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .data  (data),
        .abort (abort),
        .ready (ready),
        .busy  (busy),
        .out   (out),
        .done  (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: each falling edge shows the result of the preceding rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({out, ready, busy, done} !== {e.out, e.ready, e.busy, e.done}) begin
                    errors++;
                    $display("FAIL %s: out/ready/busy/done got %b%b%b%b expected %b%b%b%b",
                             e.tag, out, ready, busy, done, e.out, e.ready, e.busy, e.done);
                end
            end
        end
    end

    // Drive one edge worth of inputs and queue the state expected after it.
    task automatic step(input logic s, input logic [7:0] d, input logic a, input logic r,
                        input logic e_out, input logic e_ready, input logic e_busy,
                        input logic e_done, input string tag);
        exp_t e;
        start = s;
        data  = d;
        abort = a;
        reset = r;
        e.out = e_out; e.ready = e_ready; e.busy = e_busy; e.done = e_done; e.tag = tag;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, tag);
    endtask

    // Full 14-cycle frame. bits = hand-computed line sequence (sync + payload).
    // Data is inverted after the accepting edge; hold drives start afterwards;
    // at step ign_k a second start with data 0 is attempted.
    task automatic frame(input logic [7:0] d, input logic [11:0] bits, input logic hold,
                         input int ign_k, input string tag);
        logic s;
        logic [7:0] dd;
        for (int k = 0; k < 14; k++) begin
            s  = (k == 0) ? 1'b1 : hold;
            dd = (k == 0) ? d : ~d;
            if (k == ign_k) begin
                s  = 1'b1;
                dd = 8'h00;
            end
            if (k < 12)
                step(s, dd, 1'b0, 1'b0, bits[11-k], 1'b0, 1'b1, 1'b0, $sformatf("%s k%0d", tag, k));
            else if (k == 12)
                step(s, dd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, $sformatf("%s gap0", tag));
            else
                step(s, dd, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, $sformatf("%s gap1", tag));
        end
    endtask

    // First n cycles of a frame, then one edge with abort/start/reset as given.
    task automatic partial(input logic [7:0] d, input logic [11:0] bits, input int n,
                           input logic a, input logic s, input logic r, input string tag);
        for (int k = 0; k < n; k++)
            step((k == 0) ? 1'b1 : 1'b0, d, 1'b0, 1'b0, bits[11-k], 1'b0, 1'b1, 1'b0,
                 $sformatf("%s k%0d", tag, k));
        step(s, d, a, r, 1'b0, 1'b1, 1'b0, 1'b0, $sformatf("%s cut", tag));
    endtask

    initial begin
        start = 1'b0; data = 8'h00; abort = 1'b0; reset = 1'b0;

        // Reset for two edges, then quiet idle.
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "rst0");
        step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "rst1");
        idle(5, "idle");

        // Single frame A5: 1001 10100101.
        frame(8'hA5, 12'b1001_1010_0101, 1'b0, -1, "a5");
        idle(2, "a5 post");

        // All-zero payload: sync followed by a flat low line.
        frame(8'h00, 12'b1001_0000_0000, 1'b0, -1, "z00");
        idle(2, "z00 post");

        // Start at N+3 with data 00 is ignored; no second frame follows.
        frame(8'hFF, 12'b1001_1111_1111, 1'b0, 3, "ign");
        idle(4, "ign post");

        // Abort at N+6 during payload F0.
        partial(8'hF0, 12'b1001_1111_0000, 6, 1'b1, 1'b0, 1'b0, "abort");
        idle(3, "abort post");

        // Abort together with start at N+6: no relaunch.
        partial(8'hF0, 12'b1001_1111_0000, 6, 1'b1, 1'b1, 1'b0, "abst");
        idle(3, "abst post");

        // Reset at N+5, with start and abort also high.
        partial(8'hA5, 12'b1001_1010_0101, 5, 1'b1, 1'b1, 1'b1, "rstmid");
        idle(3, "rstmid post");

        // Start held high: second frame begins exactly at N+14.
        frame(8'h3C, 12'b1001_0011_1100, 1'b1, -1, "b2b0");
        frame(8'h3C, 12'b1001_0011_1100, 1'b0, -1, "b2b1");
        idle(3, "b2b post");

        // Let the monitor drain, bounded.
        for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial frame transmitter; it is the driving end of the serial sync-pattern detector (my_fsm) link.
- It emits a fixed sync pattern (default 1001), then a parallel payload word serialized MSB first, then a low guard gap.
- It sits upstream of the detector on the single-bit line and produces stimulus and traffic that the detector recognises.

Parameters:
- SYNC_PATTERN, 4'b1001: sync bits, sent MSB first.
- SYNC_LEN, 4: number of sync bits (1..16).
- DATA_W, 8: payload width in bits (1..32).
- GAP_LEN, 2: guard cycles of low output after the payload (must be >= 1).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request to send a frame; sampled only when ready=1
- data  input  DATA_W  payload; captured on the accepted start edge
- abort  input  1  synchronous abort of the frame in flight
- ready  output  1  high when idle and able to accept start
- busy  output  1  high while sync, payload or gap is being sent
- out  output  1  registered serial line
- done  output  1  one-cycle pulse when the payload completes normally

Behaviour:
- Reset (reset=1 at a rising edge):
  - state=IDLE, out=0, busy=0, done=0, ready=1, counters=0, shift register=0.
  - Reset overrides start and abort.
- States: IDLE, SYNC, DATA, GAP. All outputs are registered.
- IDLE:
  - out=0, ready=1, busy=0.
  - Edge N with start=1 and abort=0: capture data into the shift register, go to SYNC, bit counter=0.
  - After edge N: out=SYNC_PATTERN[SYNC_LEN-1], busy=1, ready=0.
- SYNC:
  - Each edge presents the next sync bit, MSB first.
  - After edge N+k (k < SYNC_LEN), out=SYNC_PATTERN[SYNC_LEN-1-k].
  - After the last sync bit, go to DATA.
- DATA:
  - After edge N+SYNC_LEN+j (j < DATA_W), out=data[DATA_W-1-j].
  - After the last payload bit, go to GAP.
- GAP:
  - out=0 for GAP_LEN cycles.
  - done=1 in the first GAP cycle only.
  - After the last GAP cycle, go to IDLE: ready=1, busy=0.
  - The first edge at which a new start can be accepted is N+SYNC_LEN+DATA_W+GAP_LEN.
- Total frame occupancy: SYNC_LEN+DATA_W+GAP_LEN cycles.
- start while ready=0 is ignored and is not queued.
- data is only sampled on the accepted start edge; changes to data mid-frame have no effect.
- abort=1 at any edge while busy: next state IDLE, out=0, busy=0, ready=1, done=0.
  - abort takes priority over start on the same edge; start is dropped.
  - abort while in IDLE has no effect.
- Back-to-back frames: a start held high continuously relaunches at the first ready edge. Frames are therefore separated by exactly GAP_LEN low cycles.
- Counters:
  - One bit counter of width clog2(max(SYNC_LEN, DATA_W, GAP_LEN)+1), cleared on every state change.
  - No wrap-around within a state; the terminal count forces the transition.
- A payload that contains the sync pattern is not escaped; framing ambiguity on the receive side is outside this block's scope.

Decomposition:
- Shared package seq_pkg holds:
  - the state enum (IDLE, SYNC, DATA, GAP);
  - the default sync constant 4'b1001 and its length, so the transmitter and detector share one definition.
- One natural sub-module: piso_shift.
  - Parallel-load, MSB-first shift register, width DATA_W.
  - Ports: load, shift_en, d, q_msb.
  - Used for the payload; the sync bits are indexed directly from the parameter.

Test Plan:
- Reset then idle: hold reset for 2 edges, release, and wait 5 cycles -> out=0, ready=1, busy=0, done=0 throughout.
- Single frame, data=8'hA5, start for 1 cycle at edge N -> out after edges N..N+11 = 1,0,0,1,1,0,1,0,0,1,0,1; out=0 after edges N+12 and N+13; done=1 only after edge N+12; ready=1 after edge N+13.
- Loopback into my_fsm with data=8'h00 -> the detector asserts its output on the cycle after the 4th sync bit; ready and done timing are as in the single-frame case.
- Start ignored while busy: start at N with data=8'hFF, then start at N+3 with data=8'h00 -> payload bits are all 1; exactly one done pulse; no second frame starts.
- Abort mid-payload: data=8'hF0, abort at N+6 -> out=0, busy=0, ready=1 after edge N+6; no done pulse.
- Abort and start together at N+6 -> the frame is not relaunched.
- Reset mid-frame and back-to-back:
  - reset=1 at N+5 -> all outputs at reset values after that edge.
  - start held high with data=8'h3C -> second frame begins at edge N+14; the two frames are separated by exactly 2 low cycles.
